inst_fetch: RTL and testbench

Instruction fetch stage of the MIPS pipeline: owns the PC, issues in-order reads to instruction memory and buffers returned words in a small FIFO. It presents the oldest instruction with its fields pre-split (op, rs, rt, rd, func, shamt, imm, target) to the control-unit decode stage. It takes PC redirects from the branch/jump resolution logic and flushes wrong-path instructions.

---
 rtl/inst_fetch.sv | 150 +++++++++++++++
 tb/tb_inst_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// MIPS instruction fetch stage: PC ownership, credit-limited in-order imem reads,
// response FIFO with redirect flush. Optional same-cycle bypass: INST_FETCH_BYPASS_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] target
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] r_pc;
  logic [31:0] r_resp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_kill;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  entry_t        r_mem [DEPTH];

  logic        w_credit;
  logic        w_issue;
  logic        w_resp;
  logic        w_killed;
  logic        w_accept;
  logic        w_empty;
  logic        w_bypass;
  logic        w_push;
  logic        w_fifo_pop;
  logic [31:0] w_redir_pc;
  entry_t      w_head;
  entry_t      w_out;

  assign w_redir_pc = redirect_pc & ~32'h3;
  assign w_credit   = ((CW+1)'(r_outst) + (CW+1)'(r_count)) < (CW+1)'(DEPTH);
  assign imem_req   = rst_n & ~redirect & w_credit;
  assign imem_addr  = r_pc;
  assign w_issue    = imem_req & imem_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp   = imem_rvalid & (r_outst != '0);
  assign w_killed = w_resp & (r_kill != '0);
  assign w_accept = w_resp & (r_kill == '0) & ~redirect;
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rd_ptr];

  // Head selection: FIFO entry, or the live response when bypass is enabled and the FIFO is empty.
  always_comb begin
    w_out    = w_head;
    w_bypass = 1'b0;
`ifdef INST_FETCH_BYPASS_EN
    w_bypass = w_accept & w_empty;
    if (w_bypass) begin
      w_out.word = imem_rdata;
      w_out.pc   = r_resp_pc;
    end
`endif
  end

  assign inst_valid = ~w_empty | w_bypass;
  assign w_push     = w_accept & ~(w_bypass & ~stall);
  assign w_fifo_pop = ~w_empty & ~stall & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_outst   <= '0;
      r_kill    <= '0;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
    end else if (redirect) begin
      // Everything still in flight is wrong-path; the response landing now is dropped too.
      r_pc      <= w_redir_pc;
      r_resp_pc <= w_redir_pc;
      r_outst   <= r_outst - CW'(w_resp);
      r_kill    <= r_outst - CW'(w_resp);
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      r_outst <= r_outst + CW'(w_issue) - CW'(w_resp);
      if (w_killed) begin
        r_kill <= r_kill - CW'(1);
      end
      if (w_accept) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (w_push && !redirect) begin
      r_mem[r_wr_ptr] <= '{word: imem_rdata, pc: r_resp_pc};
    end
  end

  assign inst     = w_out.word;
  assign inst_pc  = w_out.pc;
  assign pc_plus4 = w_out.pc + 32'd4;
  assign op       = w_out.word[31:26];
  assign rs       = w_out.word[25:21];
  assign rt       = w_out.word[20:16];
  assign rd       = w_out.word[15:11];
  assign shamt    = w_out.word[10:6];
  assign func     = w_out.word[5:0];
  assign imm      = w_out.word[15:0];
  assign target   = w_out.word[25:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: randomized memory latency/ready/stall/redirect against a
// program-order stream model (expected PC sequence restarting at each redirect).
module tb_inst_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc, pc_plus4;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imm(imm), .target(target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } req_t;

  req_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          buffered = 0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] issue_pc = 32'h0;
  bit          saw_zero = 0;
  bit          have_resp = 0;
  bit          found;

  // Instruction memory contents: a fixed mix of the address, with one known R-type word at 0x8.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h8) return 32'h012A_4020;
    return {a[15:0], a[31:16]} ^ (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the stream model.
  task automatic cycle(input bit st, input bit rdir, input logic [31:0] tgt, input bit rdy);
    req_t        h;
    bit          resp_ok, valid_exp, exp_req;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    stall       = st;
    redirect    = rdir;
    redirect_pc = tgt;
    imem_ready  = rdy;
    have_resp   = (q.size() != 0) && (q[0].due <= cyc);
    imem_rvalid = have_resp;
    imem_rdata  = have_resp ? memfn(q[0].addr) : $urandom();
    #1;
    exp_req = !rdir && ((q.size() + buffered) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("outstanding_bound", 32'(q.size() <= DEPTH), 32'd1);
    resp_ok = 1'b0;
    if (have_resp) begin
      h = q.pop_front();
      resp_ok = !h.stale && !rdir;
    end
`ifdef INST_FETCH_BYPASS_EN
    valid_exp = (buffered != 0) || resp_ok;
`else
    valid_exp = (buffered != 0);
`endif
    chk("inst_valid", 32'(inst_valid), 32'(valid_exp));
    if (valid_exp) begin
      w = memfn(exp_pc);
      chk("inst", inst, w);
      chk("inst_pc", inst_pc, exp_pc);
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk("op", 32'(op), 32'(w[31:26]));
      chk("rs", 32'(rs), 32'(w[25:21]));
      chk("rt", 32'(rt), 32'(w[20:16]));
      chk("rd", 32'(rd), 32'(w[15:11]));
      chk("shamt", 32'(shamt), 32'(w[10:6]));
      chk("func", 32'(func), 32'(w[5:0]));
      chk("imm", 32'(imm), 32'(w[15:0]));
      chk("target", 32'(target), 32'(w[25:0]));
      if (exp_pc == 32'h8) begin
        chk("split_op", 32'(op), 32'd0);
        chk("split_rs", 32'(rs), 32'd9);
        chk("split_rt", 32'(rt), 32'd10);
        chk("split_rd", 32'(rd), 32'd8);
        chk("split_func", 32'(func), 32'h20);
      end
    end
    if (resp_ok) begin
      buffered++;
      chk("fifo_no_overflow", 32'(buffered <= DEPTH), 32'd1);
    end
    if (valid_exp && !st && !rdir) begin
      if (inst_pc === 32'h0) saw_zero = 1'b1;
      buffered--;
      exp_pc = exp_pc + 32'd4;
    end
    if (rdir) begin
      buffered = 0;
      foreach (q[i]) q[i].stale = 1'b1;
      exp_pc   = tgt & ~32'h3;
      issue_pc = tgt & ~32'h3;
    end
    if (imem_req && rdy) begin
      chk("imem_addr", imem_addr, issue_pc);
      q.push_back('{addr: issue_pc, due: cyc + $urandom_range(lat_max, lat_min), stale: 1'b0});
      issue_pc = issue_pc + 32'd4;
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #12;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory, in-order stream from reset PC.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Long stall: credit must throttle, nothing lost or duplicated.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with two reads outstanding: both must be dropped.
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (q.size() >= 2) found = 1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("two_outstanding_reached", 32'(found), 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redirect_addr_next", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as a response and a pop.
    lat_min = 1; lat_max = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (buffered > 0 && q.size() != 0 && q[0].due <= cyc + 1 && !q[0].stale) found = 1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("coincident_setup_reached", 32'(found), 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("flush_inst_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // PC wrap across the top of the address space.
    saw_zero = 0;
    cycle(1'b0, 1'b1, 32'hFFFF_FFF6, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pc_wrapped_to_zero", 32'(saw_zero), 32'd1);

    // Random ready, latency 1..3, stalls and redirects.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)))
                                      : $urandom();
      cycle(($urandom_range(3, 0) == 0), ($urandom_range(24, 0) == 0), t,
            ($urandom_range(1, 0) == 1));
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
